// File: rtl/slice_serializer.sv
// rtl/slice_serializer.sv - registered width-down converter: one wide word out as SLICE_W slices per beat
module slice_serializer #(
  parameter int IN_W      = 16,
  parameter int SLICE_W   = 4,
  parameter int MSB_FIRST = 0,
  parameter int CW        = $clog2(IN_W / SLICE_W + 1)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic [CW-1:0]      in_nslices,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic [CW-1:0]      out_idx,
  output logic               out_last
);

  localparam int N = IN_W / SLICE_W;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [IN_W-1:0]      hold_q, hold_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        rem_q, rem_d;
  logic [SLICE_W-1:0]   data_q, data_d;
  logic                 last_q, last_d;
  logic                 in_fire, out_fire;
  logic [CW-1:0]        nslices_clamped;

  assign out_valid = (state_q == SHIFT);
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

  // Final beat frees the holding register, so a new word can load on the same edge.
  assign in_ready  = (state_q == IDLE) | (out_valid & out_ready & last_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign nslices_clamped = ((in_nslices == '0) || (in_nslices > CW'(N))) ? CW'(N) : in_nslices;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    if (in_fire) begin
      hold_d  = in_data;
      rem_d   = nslices_clamped;
      idx_d   = (MSB_FIRST != 0) ? CW'(N - 1) : '0;
      state_d = SHIFT;
    end else if (out_fire) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        idx_d = (MSB_FIRST != 0) ? idx_q - CW'(1) : idx_q + CW'(1);
        rem_d = rem_q - CW'(1);
      end
    end
  end

  // Slice and last flag are precomputed from next-state values so outputs come straight from flops.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_d == CW'(i)) data_d = hold_d[i*SLICE_W +: SLICE_W];
    end
    last_d = (state_d == SHIFT) && (rem_d == CW'(1));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_slice_serializer.sv
// tb/tb_slice_serializer.sv - directed bench for slice_serializer, LSB- and MSB-first instances on shared stimulus
module tb_slice_serializer;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [2:0]  in_nslices;
  logic        out_ready;

  logic        l_in_ready, l_out_valid, l_out_last;
  logic [3:0]  l_out_data;
  logic [2:0]  l_out_idx;
  logic        m_in_ready, m_out_valid, m_out_last;
  logic [3:0]  m_out_data;
  logic [2:0]  m_out_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slice_serializer #(.IN_W(16), .SLICE_W(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .in_nslices(in_nslices), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_data(l_out_data), .out_idx(l_out_idx), .out_last(l_out_last)
  );

  slice_serializer #(.IN_W(16), .SLICE_W(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .in_nslices(in_nslices), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_data(m_out_data), .out_idx(m_out_idx), .out_last(m_out_last)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the beat on both instances, then advances one edge.
  task automatic beat(input string tag, input logic [3:0] ld, input logic [2:0] li,
                      input logic [3:0] md, input logic [2:0] mi, input logic last);
    check({tag, " l_valid"}, l_out_valid, 1'b1);
    check({tag, " l_data"},  l_out_data,  ld);
    check({tag, " l_idx"},   l_out_idx,   li);
    check({tag, " l_last"},  l_out_last,  last);
    check({tag, " m_valid"}, m_out_valid, 1'b1);
    check({tag, " m_data"},  m_out_data,  md);
    check({tag, " m_idx"},   m_out_idx,   mi);
    check({tag, " m_last"},  m_out_last,  last);
    step();
  endtask

  task automatic send(input logic [15:0] word, input logic [2:0] n);
    in_valid   = 1'b1;
    in_data    = word;
    in_nslices = n;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " l_valid"}, l_out_valid, 1'b0);
    check({tag, " m_valid"}, m_out_valid, 1'b0);
    check({tag, " l_ready"}, l_in_ready,  1'b1);
  endtask

  logic [3:0] b2b_l [8];
  logic [3:0] b2b_m [8];

  initial begin
    arst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_nslices = '0; out_ready = 1'b0;
    #1;
    check("rst l_valid", l_out_valid, 1'b0);
    check("rst l_data",  l_out_data,  4'h0);
    check("rst l_idx",   l_out_idx,   3'd0);
    check("rst l_last",  l_out_last,  1'b0);
    check("rst l_ready", l_in_ready,  1'b1);
    check("rst m_valid", m_out_valid, 1'b0);
    step(); step();
    arst_n = 1'b1;
    step();
    check_idle("post_rst");

    // Full word, nslices=0 clamps to 4
    out_ready = 1'b1;
    send(16'hABCD, 3'd0);
    beat("w0 b0", 4'hD, 3'd0, 4'hA, 3'd3, 1'b0);
    beat("w0 b1", 4'hC, 3'd1, 4'hB, 3'd2, 1'b0);
    beat("w0 b2", 4'hB, 3'd2, 4'hC, 3'd1, 1'b0);
    beat("w0 b3", 4'hA, 3'd3, 4'hD, 3'd0, 1'b1);
    check_idle("w0 end");

    // Two slices only; in_ready rises while the last slice fires
    send(16'hABCD, 3'd2);
    check("n2 ready0", l_in_ready, 1'b0);
    beat("n2 b0", 4'hD, 3'd0, 4'hA, 3'd3, 1'b0);
    check("n2 ready1", l_in_ready, 1'b1);
    beat("n2 b1", 4'hC, 3'd1, 4'hB, 3'd2, 1'b1);
    check_idle("n2 end");

    // nslices=7 clamps to 4
    send(16'hABCD, 3'd7);
    beat("n7 b0", 4'hD, 3'd0, 4'hA, 3'd3, 1'b0);
    beat("n7 b1", 4'hC, 3'd1, 4'hB, 3'd2, 1'b0);
    beat("n7 b2", 4'hB, 3'd2, 4'hC, 3'd1, 1'b0);
    beat("n7 b3", 4'hA, 3'd3, 4'hD, 3'd0, 1'b1);
    check_idle("n7 end");

    // Backpressure during index 1 with a competing word offered
    send(16'h1234, 3'd0);
    beat("bp b0", 4'h4, 3'd0, 4'h1, 3'd3, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      check("bp ready", l_in_ready, 1'b0);
      step();
      check("bp valid", l_out_valid, 1'b1);
      check("bp data",  l_out_data,  4'h3);
      check("bp idx",   l_out_idx,   3'd1);
      check("bp m_data", m_out_data, 4'h2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    beat("bp b1", 4'h3, 3'd1, 4'h2, 3'd2, 1'b0);
    beat("bp b2", 4'h2, 3'd2, 4'h3, 3'd1, 1'b0);
    beat("bp b3", 4'h1, 3'd3, 4'h4, 3'd0, 1'b1);
    check_idle("bp end");

    // Back-to-back words without a gap
    b2b_l = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
    b2b_m = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    send(16'h1234, 3'd0);
    in_valid = 1'b1;
    in_data  = 16'h5678;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) check("b2b ready", l_in_ready, (i == 3) ? 1'b1 : 1'b0);
      beat("b2b", b2b_l[i], 3'(i % 4), b2b_m[i], 3'(3 - i % 4), (i % 4) == 3);
      if (i == 3) in_valid = 1'b0;
    end
    check_idle("b2b end");

    // Single-slice words stream one per cycle
    in_valid = 1'b1; in_nslices = 3'd1; in_data = 16'h000A;
    step();
    in_data = 16'hB000;
    check("k1 ready", l_in_ready, 1'b1);
    beat("k1 w0", 4'hA, 3'd0, 4'h0, 3'd3, 1'b1);
    in_valid = 1'b0;
    beat("k1 w1", 4'h0, 3'd0, 4'hB, 3'd3, 1'b1);
    check_idle("k1 end");

    // Asynchronous reset mid-word, then a clean word
    send(16'hABCD, 3'd0);
    beat("rm b0", 4'hD, 3'd0, 4'hA, 3'd3, 1'b0);
    beat("rm b1", 4'hC, 3'd1, 4'hB, 3'd2, 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    check("rm l_valid", l_out_valid, 1'b0);
    check("rm m_valid", m_out_valid, 1'b0);
    check("rm l_idx",   l_out_idx,   3'd0);
    check("rm l_data",  l_out_data,  4'h0);
    step();
    arst_n = 1'b1;
    step();
    check_idle("rm idle");
    send(16'h00F0, 3'd0);
    beat("rm2 b0", 4'h0, 3'd0, 4'h0, 3'd3, 1'b0);
    beat("rm2 b1", 4'hF, 3'd1, 4'h0, 3'd2, 1'b0);
    beat("rm2 b2", 4'h0, 3'd2, 4'hF, 3'd1, 1'b0);
    beat("rm2 b3", 4'h0, 3'd3, 4'h0, 3'd0, 1'b1);
    check_idle("rm2 end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
